jc_phase_decoder: RTL and testbench

// - Consumer stage directly downstream of the 4-bit Johnson (twisted-ring) counter.
// - Decodes each sampled Johnson code into a 3-bit phase index and an 8-bit one-hot phase strobe.
// - Checks code legality and successor sequence, and runs a lock FSM.
// - Counts full revolutions (phase 7 -> phase 0) for downstream clock-phase / sequencing logic.

---
 rtl/jc_pkg.sv | 46 ++++
 rtl/jc_phase_decoder_if.sv | 33 +++
 rtl/jc_code_decode.sv | 17 +
 rtl/jc_phase_decoder.sv | 154 +++++++++++++++
 tb/tb_jc_phase_decoder.sv | 226 ++++++++++++++++++++++
 5 files changed

// File: rtl/jc_pkg.sv
// Shared definitions for the Johnson-counter phase decoder slice.
//   - JC_P0..JC_P7 : the eight legal 4-bit Johnson codes, phase order
//   - jc_state_e   : lock FSM state encoding (SEARCH=0, LOCKED=1)
//   - jc_dec_t     : decode result {legal, idx}
//   - jc_decode()  : 4-bit code -> jc_dec_t
package jc_pkg;

  localparam logic [3:0] JC_P0 = 4'b0000;
  localparam logic [3:0] JC_P1 = 4'b1000;
  localparam logic [3:0] JC_P2 = 4'b1100;
  localparam logic [3:0] JC_P3 = 4'b1110;
  localparam logic [3:0] JC_P4 = 4'b1111;
  localparam logic [3:0] JC_P5 = 4'b0111;
  localparam logic [3:0] JC_P6 = 4'b0011;
  localparam logic [3:0] JC_P7 = 4'b0001;

  typedef enum logic {
    ST_SEARCH = 1'b0,
    ST_LOCKED = 1'b1
  } jc_state_e;

  typedef struct packed {
    logic       legal;
    logic [2:0] idx;
  } jc_dec_t;

  // Codes outside the twisted-ring sequence decode as illegal with idx 0.
  function automatic jc_dec_t jc_decode(input logic [3:0] code);
    jc_dec_t d;
    d.legal = 1'b1;
    d.idx   = 3'd0;
    case (code)
      JC_P0:   d.idx = 3'd0;
      JC_P1:   d.idx = 3'd1;
      JC_P2:   d.idx = 3'd2;
      JC_P3:   d.idx = 3'd3;
      JC_P4:   d.idx = 3'd4;
      JC_P5:   d.idx = 3'd5;
      JC_P6:   d.idx = 3'd6;
      JC_P7:   d.idx = 3'd7;
      default: d.legal = 1'b0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/jc_phase_decoder_if.sv
// Signal bundle between the upstream Johnson counter side and the decoder.
//   master : drives sample_en, jc_q, clear_err; observes decoder outputs
//   slave  : the decoder (jc_phase_decoder)
//   sample_en/jc_q/clear_err : new-code strobe, sampled code, sticky clear
//   phase_idx/phase_oh       : decoded phase (binary / one-hot)
//   locked, err_illegal, err_seq, err_sticky, rev_count, rev_tick : status
interface jc_phase_decoder_if #(
  parameter int unsigned REV_W = 8
);
  logic             sample_en;
  logic [3:0]       jc_q;
  logic             clear_err;
  logic [2:0]       phase_idx;
  logic [7:0]       phase_oh;
  logic             locked;
  logic             err_illegal;
  logic             err_seq;
  logic             err_sticky;
  logic [REV_W-1:0] rev_count;
  logic             rev_tick;

  modport master (
    output sample_en, jc_q, clear_err,
    input  phase_idx, phase_oh, locked, err_illegal, err_seq,
           err_sticky, rev_count, rev_tick
  );

  modport slave (
    input  sample_en, jc_q, clear_err,
    output phase_idx, phase_oh, locked, err_illegal, err_seq,
           err_sticky, rev_count, rev_tick
  );
endinterface

// File: rtl/jc_code_decode.sv
// Combinational Johnson code decoder.
//   code  in  4 : sampled Johnson code
//   legal out 1 : code is one of the eight ring codes
//   idx   out 3 : phase index (0 when illegal)
module jc_code_decode
  import jc_pkg::*;
(
  input  logic [3:0] code,
  output logic       legal,
  output logic [2:0] idx
);
  jc_dec_t dec;

  assign dec   = jc_decode(code);
  assign legal = dec.legal;
  assign idx   = dec.idx;
endmodule

// File: rtl/jc_phase_decoder.sv
// Phase decoder stage behind a 4-bit Johnson counter. Registers the decoded
// phase, checks legality and successor order, runs a SEARCH/LOCKED FSM and
// counts 7->0 revolutions while locked. All outputs lag the sample by one clk.
//   clk   in : rising-edge clock
//   rst_n in : asynchronous active-low reset
//   bus      : jc_phase_decoder_if.slave (inputs sample_en/jc_q/clear_err,
//              outputs phase_idx/phase_oh/locked/err_*/rev_count/rev_tick)
// Parameters: LOCK_CNT (1..15) successors to lock, REV_W counter width,
//             ALLOW_HOLD 1 = repeated code is a legal stall.
module jc_phase_decoder
  import jc_pkg::*;
#(
  parameter int unsigned LOCK_CNT   = 4,
  parameter int unsigned REV_W      = 8,
  parameter bit          ALLOW_HOLD = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  jc_phase_decoder_if.slave bus
);
  localparam logic [3:0]       LOCK_TGT = 4'(LOCK_CNT);
  localparam logic [REV_W-1:0] REV_ONE  = REV_W'(1);

  jc_state_e        state_q, state_d;
  logic [3:0]       streak_q, streak_d;
  logic [2:0]       prev_q, prev_d;
  logic             prev_valid_q, prev_valid_d;
  logic [2:0]       phase_idx_q, phase_idx_d;
  logic [7:0]       phase_oh_q, phase_oh_d;
  logic             err_illegal_q, err_illegal_d;
  logic             err_seq_q, err_seq_d;
  logic             err_sticky_q, err_sticky_d;
  logic [REV_W-1:0] rev_count_q, rev_count_d;
  logic             rev_tick_q, rev_tick_d;

  logic             dec_legal;
  logic [2:0]       dec_idx;
  logic [2:0]       prev_next;
  logic             is_succ;
  logic             is_hold;
  logic [3:0]       streak_inc;

  jc_code_decode u_dec (
    .code  (bus.jc_q),
    .legal (dec_legal),
    .idx   (dec_idx)
  );

  // 3-bit add wraps 7 -> 0, giving the modulo-8 successor directly.
  assign prev_next  = prev_q + 3'd1;
  assign is_succ    = prev_valid_q && (dec_idx == prev_next);
  assign is_hold    = ALLOW_HOLD && prev_valid_q && (dec_idx == prev_q);
  assign streak_inc = streak_q + 4'd1;

  always_comb begin
    state_d       = state_q;
    streak_d      = streak_q;
    prev_d        = prev_q;
    prev_valid_d  = prev_valid_q;
    phase_idx_d   = phase_idx_q;
    phase_oh_d    = phase_oh_q;
    err_illegal_d = 1'b0;
    err_seq_d     = 1'b0;
    rev_count_d   = rev_count_q;
    rev_tick_d    = 1'b0;

    if (bus.sample_en) begin
      if (!dec_legal) begin
        // Phase outputs keep the last legal value; sequence tracking restarts.
        err_illegal_d = 1'b1;
        state_d       = ST_SEARCH;
        streak_d      = '0;
        prev_valid_d  = 1'b0;
      end else begin
        phase_idx_d  = dec_idx;
        phase_oh_d   = 8'b1 << dec_idx;
        prev_d       = dec_idx;
        prev_valid_d = 1'b1;
        case (state_q)
          ST_SEARCH: begin
            if (is_succ) begin
              if (streak_inc == LOCK_TGT) begin
                state_d  = ST_LOCKED;
                streak_d = '0;
              end else begin
                streak_d = streak_inc;
              end
            end else if (!is_hold) begin
              streak_d = '0;
            end
          end
          ST_LOCKED: begin
            if (!is_succ && !is_hold) begin
              err_seq_d = 1'b1;
              state_d   = ST_SEARCH;
              streak_d  = '0;
            end else if (is_succ && (prev_q == 3'd7)) begin
              rev_count_d = rev_count_q + REV_ONE;
              rev_tick_d  = 1'b1;
            end
          end
          default: state_d = ST_SEARCH;
        endcase
      end
    end

    // A new error outranks a simultaneous clear.
    if (err_illegal_d || err_seq_d) begin
      err_sticky_d = 1'b1;
    end else if (bus.clear_err) begin
      err_sticky_d = 1'b0;
    end else begin
      err_sticky_d = err_sticky_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_SEARCH;
      streak_q      <= '0;
      prev_q        <= '0;
      prev_valid_q  <= 1'b0;
      phase_idx_q   <= '0;
      phase_oh_q    <= '0;
      err_illegal_q <= 1'b0;
      err_seq_q     <= 1'b0;
      err_sticky_q  <= 1'b0;
      rev_count_q   <= '0;
      rev_tick_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      streak_q      <= streak_d;
      prev_q        <= prev_d;
      prev_valid_q  <= prev_valid_d;
      phase_idx_q   <= phase_idx_d;
      phase_oh_q    <= phase_oh_d;
      err_illegal_q <= err_illegal_d;
      err_seq_q     <= err_seq_d;
      err_sticky_q  <= err_sticky_d;
      rev_count_q   <= rev_count_d;
      rev_tick_q    <= rev_tick_d;
    end
  end

  assign bus.phase_idx   = phase_idx_q;
  assign bus.phase_oh    = phase_oh_q;
  assign bus.locked      = (state_q == ST_LOCKED);
  assign bus.err_illegal = err_illegal_q;
  assign bus.err_seq     = err_seq_q;
  assign bus.err_sticky  = err_sticky_q;
  assign bus.rev_count   = rev_count_q;
  assign bus.rev_tick    = rev_tick_q;

endmodule

// File: tb/tb_jc_phase_decoder.sv
// Bench for jc_phase_decoder: two instances (ALLOW_HOLD=1 "H", ALLOW_HOLD=0
// "S") share one stimulus stream and are compared against a phase-level
// reference model every cycle, plus targeted directed checks.
module tb_jc_phase_decoder;
  localparam int unsigned LOCK_CNT = 4;
  localparam int unsigned REV_W    = 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  jc_phase_decoder_if #(.REV_W(REV_W)) bus_h ();
  jc_phase_decoder_if #(.REV_W(REV_W)) bus_s ();

  jc_phase_decoder #(.LOCK_CNT(LOCK_CNT), .REV_W(REV_W), .ALLOW_HOLD(1'b1)) dut_h (
    .clk (clk), .rst_n (rst_n), .bus (bus_h.slave)
  );
  jc_phase_decoder #(.LOCK_CNT(LOCK_CNT), .REV_W(REV_W), .ALLOW_HOLD(1'b0)) dut_s (
    .clk (clk), .rst_n (rst_n), .bus (bus_s.slave)
  );

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;
  string       cur   = "reset";

  logic [3:0] codes [8] = '{4'h0, 4'h8, 4'hC, 4'hE, 4'hF, 4'h7, 4'h3, 4'h1};
  bit         allow [2] = '{1'b1, 1'b0};

  // Reference model state, index 0 = H instance, 1 = S instance.
  bit m_lock [2];
  int m_streak [2];
  int m_prev [2];
  bit m_pv [2];
  int m_ph [2];
  bit m_seen [2];
  bit m_ei [2];
  bit m_es [2];
  bit m_st [2];
  bit m_tick [2];
  int m_rev [2];

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_lock[k] = 0; m_streak[k] = 0; m_prev[k] = 0; m_pv[k] = 0;
      m_ph[k] = 0; m_seen[k] = 0; m_ei[k] = 0; m_es[k] = 0;
      m_st[k] = 0; m_tick[k] = 0; m_rev[k] = 0;
    end
  endtask

  task automatic model_step(input bit en, input logic [3:0] code, input bit clr);
    for (int k = 0; k < 2; k++) begin
      int idx;
      bit succ;
      bit hold;
      m_ei[k] = 0; m_es[k] = 0; m_tick[k] = 0;
      if (en) begin
        idx = -1;
        for (int i = 0; i < 8; i++) if (codes[i] == code) idx = i;
        if (idx < 0) begin
          m_ei[k] = 1; m_lock[k] = 0; m_streak[k] = 0; m_pv[k] = 0;
        end else begin
          succ = m_pv[k] && (idx == (m_prev[k] + 1) % 8);
          hold = m_pv[k] && (idx == m_prev[k]) && allow[k];
          if (m_lock[k]) begin
            if (!succ && !hold) begin
              m_es[k] = 1; m_lock[k] = 0; m_streak[k] = 0;
            end else if (succ && idx == 0) begin
              m_rev[k] = (m_rev[k] + 1) % (1 << REV_W);
              m_tick[k] = 1;
            end
          end else if (succ) begin
            m_streak[k]++;
            if (m_streak[k] == LOCK_CNT) begin
              m_lock[k] = 1; m_streak[k] = 0;
            end
          end else if (!hold) begin
            m_streak[k] = 0;
          end
          m_prev[k] = idx; m_pv[k] = 1; m_ph[k] = idx; m_seen[k] = 1;
        end
      end
      if (m_ei[k] || m_es[k]) m_st[k] = 1;
      else if (clr) m_st[k] = 0;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_one(input string nm, input int k,
                           input logic [2:0] ph, input logic [7:0] oh,
                           input logic lk, input logic ei, input logic es,
                           input logic st, input logic [REV_W-1:0] rc,
                           input logic tk);
    string p;
    p = {cur, " ", nm};
    chk({p, " phase_idx"},   32'(ph), 32'(m_ph[k]));
    chk({p, " phase_oh"},    32'(oh), m_seen[k] ? (32'd1 << m_ph[k]) : 32'd0);
    chk({p, " locked"},      32'(lk), 32'(m_lock[k]));
    chk({p, " err_illegal"}, 32'(ei), 32'(m_ei[k]));
    chk({p, " err_seq"},     32'(es), 32'(m_es[k]));
    chk({p, " err_sticky"},  32'(st), 32'(m_st[k]));
    chk({p, " rev_count"},   32'(rc), 32'(m_rev[k]));
    chk({p, " rev_tick"},    32'(tk), 32'(m_tick[k]));
  endtask

  task automatic check_all();
    check_one("H", 0, bus_h.phase_idx, bus_h.phase_oh, bus_h.locked, bus_h.err_illegal,
              bus_h.err_seq, bus_h.err_sticky, bus_h.rev_count, bus_h.rev_tick);
    check_one("S", 1, bus_s.phase_idx, bus_s.phase_oh, bus_s.locked, bus_s.err_illegal,
              bus_s.err_seq, bus_s.err_sticky, bus_s.rev_count, bus_s.rev_tick);
  endtask

  task automatic drive(input bit en, input logic [3:0] code, input bit clr);
    bus_h.sample_en = en; bus_h.jc_q = code; bus_h.clear_err = clr;
    bus_s.sample_en = en; bus_s.jc_q = code; bus_s.clear_err = clr;
  endtask

  // One clock: apply inputs, let the edge take them, check 2 time units later.
  task automatic cycle(input bit en, input logic [3:0] code, input bit clr);
    drive(en, code, clr);
    @(posedge clk);
    model_step(en, code, clr);
    #2;
    check_all();
  endtask

  initial begin
    int unsigned sp;
    int unsigned r;
    bit          en;
    bit          clr;
    logic [3:0]  code;

    drive(1'b0, 4'h0, 1'b0);
    model_reset();
    #12;
    check_all();
    @(negedge clk);
    rst_n = 1'b1;

    cur = "lock";
    for (int i = 0; i < 5; i++) cycle(1'b1, codes[i], 1'b0);
    chk("lock H locked", 32'(bus_h.locked), 32'd1);
    chk("lock H phase_idx", 32'(bus_h.phase_idx), 32'd4);
    chk("lock H phase_oh", 32'(bus_h.phase_oh), 32'h10);

    cur = "idle";
    cycle(1'b0, 4'hA, 1'b0);

    cur = "rev1";
    for (int i = 5; i < 8; i++) cycle(1'b1, codes[i], 1'b0);
    cycle(1'b1, codes[0], 1'b0);
    chk("rev1 H rev_tick", 32'(bus_h.rev_tick), 32'd1);
    chk("rev1 H rev_count", 32'(bus_h.rev_count), 32'd1);

    cur = "wrap";
    for (int rv = 0; rv < 255; rv++)
      for (int p = 1; p <= 8; p++) cycle(1'b1, codes[p % 8], 1'b0);
    chk("wrap H rev_count", 32'(bus_h.rev_count), 32'd0);

    cur = "illegal";
    cycle(1'b1, codes[1], 1'b0);
    cycle(1'b1, codes[2], 1'b0);
    cycle(1'b1, 4'hA, 1'b0);
    chk("illegal H err_illegal", 32'(bus_h.err_illegal), 32'd1);
    chk("illegal H locked", 32'(bus_h.locked), 32'd0);
    chk("illegal H phase_idx", 32'(bus_h.phase_idx), 32'd2);

    cur = "seq";
    for (int p = 3; p <= 10; p++) cycle(1'b1, codes[p % 8], 1'b0);
    chk("seq H locked@2", 32'(bus_h.locked), 32'd1);
    cycle(1'b1, codes[4], 1'b1);
    chk("seq H err_seq", 32'(bus_h.err_seq), 32'd1);
    chk("seq H err_sticky", 32'(bus_h.err_sticky), 32'd1);
    cycle(1'b0, 4'h0, 1'b1);
    chk("seq H sticky cleared", 32'(bus_h.err_sticky), 32'd0);

    cur = "hold";
    for (int p = 5; p <= 11; p++) cycle(1'b1, codes[p % 8], 1'b0);
    cycle(1'b1, codes[3], 1'b0);
    chk("hold H locked", 32'(bus_h.locked), 32'd1);
    chk("hold H err_seq", 32'(bus_h.err_seq), 32'd0);
    chk("hold S err_seq", 32'(bus_s.err_seq), 32'd1);
    chk("hold S locked", 32'(bus_s.locked), 32'd0);

    cur = "random";
    sp = 3;
    for (int i = 0; i < 600; i++) begin
      r = $urandom_range(0, 99);
      if (r < 65) begin
        sp = (sp + 1) % 8; code = codes[sp];
      end else if (r < 78) begin
        code = codes[sp];
      end else if (r < 90) begin
        sp = $urandom_range(0, 7); code = codes[sp];
      end else begin
        code = 4'($urandom_range(0, 15));
      end
      en  = ($urandom_range(0, 9) != 0);
      clr = ($urandom_range(0, 15) == 0);
      cycle(en, code, clr);
    end

    cur = "async";
    for (int p = 0; p < 14; p++) cycle(1'b1, codes[p % 8], 1'b0);
    #1;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_all();
    @(negedge clk);
    rst_n = 1'b1;
    cur = "post";
    cycle(1'b1, codes[5], 1'b0);
    cycle(1'b1, codes[6], 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
